// File: rtl/hazard_controller_if.sv
// Hazard controller bundle.
// Groups the pipeline hazard inputs (ID source registers, EX load/branch
// status, MEM data-memory handshake) with the per-stage enables/flushes,
// the error flag, FSM state and performance counters driven back.
//   master : pipeline side, drives hazard inputs, observes controls
//   slave  : hazard_controller side
interface hazard_controller_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs1_id;
    logic [4:0]       rs2_id;
    logic             rs1_used_id;
    logic             rs2_used_id;
    logic [4:0]       RD_ex;
    logic             DMRd_ex;
    logic             br_taken_ex;
    logic             dm_req_me;
    logic             dm_ready;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exme_en;
    logic             mewb_flush;
    logic             mem_err;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output rs1_id, rs2_id, rs1_used_id, rs2_used_id, RD_ex, DMRd_ex,
               br_taken_ex, dm_req_me, dm_ready,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exme_en,
               mewb_flush, mem_err, state_o, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1_id, rs2_id, rs1_used_id, rs2_used_id, RD_ex, DMRd_ex,
               br_taken_ex, dm_req_me, dm_ready,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exme_en,
               mewb_flush, mem_err, state_o, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller for the 5-stage RISC-V core.
// Resolves the hazards the EX forwarding unit cannot: load-use (one bubble),
// taken branch/jump (squash IF/ID and ID/EX) and data-memory wait states
// (freeze PC..EX/MEM, bubble into MEM/WB) with a timeout into a sticky ERROR.
// Ports:
//   clk   : core clock
//   rst_n : synchronous active-low reset
//   hif   : hazard_controller_if.slave (hazard inputs, stage controls,
//           mem_err, state_o, stall_cnt, flush_cnt)
//
// state    | meaning
// ---------+------------------------------------------------------------
// RUN      | normal flow; load-use / branch / new memory stall handled
// MEM_WAIT | data memory busy; pipeline frozen until dm_ready or timeout
// ERROR    | memory timeout; pipeline frozen, mem_err set until reset
module hazard_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_controller_if.slave  hif
);
    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERROR    = 2'b10
    } state_t;

    localparam logic [7:0] TIMEOUT_V = 8'(MEM_TIMEOUT);

    state_t           state_q, state_n;
    logic [7:0]       wcnt_q, wcnt_n;
    logic             mem_err_q;
    logic [CNT_W-1:0] stall_q, flush_q;

    logic load_use, mem_stall, freeze;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exme_en, mewb_flush;

    // x0 as destination never creates a dependency.
    assign load_use = hif.DMRd_ex && (hif.RD_ex != 5'd0) &&
                      ((hif.rs1_used_id && (hif.rs1_id == hif.RD_ex)) ||
                       (hif.rs2_used_id && (hif.rs2_id == hif.RD_ex)));
    assign mem_stall = hif.dm_req_me && !hif.dm_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            wcnt_q    <= 8'd0;
            mem_err_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            state_q   <= state_n;
            wcnt_q    <= wcnt_n;
            mem_err_q <= mem_err_q || (state_n == ST_ERROR);
            if (!pc_en && (stall_q != {CNT_W{1'b1}}))
                stall_q <= stall_q + CNT_W'(1);
            if (ifid_flush && (flush_q != {CNT_W{1'b1}}))
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_n    = state_q;
        wcnt_n     = wcnt_q;
        freeze     = 1'b0;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_en    = 1'b1;
        idex_flush = 1'b0;
        exme_en    = 1'b1;
        mewb_flush = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    // The detecting cycle already counts as the first wait cycle.
                    freeze = 1'b1;
                    wcnt_n = 8'd1;
                    state_n = (TIMEOUT_V == 8'd1) ? ST_ERROR : ST_MEM_WAIT;
                end else if (hif.br_taken_ex) begin
                    // The ID instruction is squashed, so any load-use is moot.
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (hif.dm_ready) begin
                    // Access completes: pipeline advances this very cycle.
                    state_n = ST_RUN;
                    wcnt_n  = 8'd0;
                end else begin
                    freeze = 1'b1;
                    wcnt_n = wcnt_q + 8'd1;
                    if (wcnt_n >= TIMEOUT_V)
                        state_n = ST_ERROR;
                end
            end
            ST_ERROR: begin
                freeze = 1'b1;
            end
            default: begin
                state_n = ST_RUN;
                wcnt_n  = 8'd0;
            end
        endcase

        if (freeze) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b0;
            idex_en    = 1'b0;
            idex_flush = 1'b0;
            exme_en    = 1'b0;
            mewb_flush = 1'b1;
        end
    end

    assign hif.pc_en      = pc_en;
    assign hif.ifid_en    = ifid_en;
    assign hif.ifid_flush = ifid_flush;
    assign hif.idex_en    = idex_en;
    assign hif.idex_flush = idex_flush;
    assign hif.exme_en    = exme_en;
    assign hif.mewb_flush = mewb_flush;
    assign hif.mem_err    = mem_err_q;
    assign hif.state_o    = state_q;
    assign hif.stall_cnt  = stall_q;
    assign hif.flush_cnt  = flush_q;
endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] rs1_id, rs2_id, RD_ex;
    logic rs1_used_id, rs2_used_id, DMRd_ex, br_taken_ex, dm_req_me, dm_ready;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // a: defaults, b: timeout 4, c: 4-bit counters, d: timeout 1
    hazard_controller_if #(.CNT_W(16)) if_a ();
    hazard_controller_if #(.CNT_W(16)) if_b ();
    hazard_controller_if #(.CNT_W(4))  if_c ();
    hazard_controller_if #(.CNT_W(16)) if_d ();

    hazard_controller #(.MEM_TIMEOUT(16), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .hif(if_a));
    hazard_controller #(.MEM_TIMEOUT(4),  .CNT_W(16)) dut_b (.clk(clk), .rst_n(rst_n), .hif(if_b));
    hazard_controller #(.MEM_TIMEOUT(64), .CNT_W(4))  dut_c (.clk(clk), .rst_n(rst_n), .hif(if_c));
    hazard_controller #(.MEM_TIMEOUT(1),  .CNT_W(16)) dut_d (.clk(clk), .rst_n(rst_n), .hif(if_d));

    assign if_a.rs1_id = rs1_id;           assign if_b.rs1_id = rs1_id;
    assign if_a.rs2_id = rs2_id;           assign if_b.rs2_id = rs2_id;
    assign if_a.rs1_used_id = rs1_used_id; assign if_b.rs1_used_id = rs1_used_id;
    assign if_a.rs2_used_id = rs2_used_id; assign if_b.rs2_used_id = rs2_used_id;
    assign if_a.RD_ex = RD_ex;             assign if_b.RD_ex = RD_ex;
    assign if_a.DMRd_ex = DMRd_ex;         assign if_b.DMRd_ex = DMRd_ex;
    assign if_a.br_taken_ex = br_taken_ex; assign if_b.br_taken_ex = br_taken_ex;
    assign if_a.dm_req_me = dm_req_me;     assign if_b.dm_req_me = dm_req_me;
    assign if_a.dm_ready = dm_ready;       assign if_b.dm_ready = dm_ready;
    assign if_c.rs1_id = rs1_id;           assign if_d.rs1_id = rs1_id;
    assign if_c.rs2_id = rs2_id;           assign if_d.rs2_id = rs2_id;
    assign if_c.rs1_used_id = rs1_used_id; assign if_d.rs1_used_id = rs1_used_id;
    assign if_c.rs2_used_id = rs2_used_id; assign if_d.rs2_used_id = rs2_used_id;
    assign if_c.RD_ex = RD_ex;             assign if_d.RD_ex = RD_ex;
    assign if_c.DMRd_ex = DMRd_ex;         assign if_d.DMRd_ex = DMRd_ex;
    assign if_c.br_taken_ex = br_taken_ex; assign if_d.br_taken_ex = br_taken_ex;
    assign if_c.dm_req_me = dm_req_me;     assign if_d.dm_req_me = dm_req_me;
    assign if_c.dm_ready = dm_ready;       assign if_d.dm_ready = dm_ready;

    task automatic idle_inputs();
        rs1_id = 0; rs2_id = 0; RD_ex = 0; rs1_used_id = 0; rs2_used_id = 0;
        DMRd_ex = 0; br_taken_ex = 0; dm_req_me = 0; dm_ready = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (if_a.state_o !== 2'b00) begin failures++; $display("FAIL reset_state got=%b exp=00", if_a.state_o); end
        checks++; if (if_a.mem_err !== 1'b0) begin failures++; $display("FAIL reset_mem_err got=%b exp=0", if_a.mem_err); end
        checks++; if (if_a.stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", if_a.stall_cnt); end
        checks++; if (if_a.flush_cnt !== 16'd0) begin failures++; $display("FAIL reset_flush_cnt got=%0d exp=0", if_a.flush_cnt); end
        checks++; if ({if_a.pc_en, if_a.ifid_en, if_a.idex_en, if_a.exme_en} !== 4'b1111)
            begin failures++; $display("FAIL reset_enables got=%b exp=1111", {if_a.pc_en, if_a.ifid_en, if_a.idex_en, if_a.exme_en}); end
        checks++; if ({if_a.ifid_flush, if_a.idex_flush, if_a.mewb_flush} !== 3'b000)
            begin failures++; $display("FAIL reset_flushes got=%b exp=000", {if_a.ifid_flush, if_a.idex_flush, if_a.mewb_flush}); end
    endtask

    task automatic test_load_use();
        do_reset();
        DMRd_ex = 1; RD_ex = 5; rs1_id = 5; rs1_used_id = 1;
        #1;
        // pc_en, ifid_en, idex_en, idex_flush, exme_en, ifid_flush
        checks++; if ({if_a.pc_en, if_a.ifid_en, if_a.idex_en, if_a.idex_flush, if_a.exme_en, if_a.ifid_flush} !== 6'b001110)
            begin failures++; $display("FAIL load_use_rs1 got=%b exp=001110",
                {if_a.pc_en, if_a.ifid_en, if_a.idex_en, if_a.idex_flush, if_a.exme_en, if_a.ifid_flush}); end
        tick();
        DMRd_ex = 0;
        #1;
        checks++; if ({if_a.pc_en, if_a.ifid_en, if_a.idex_flush} !== 3'b110)
            begin failures++; $display("FAIL load_use_release got=%b exp=110", {if_a.pc_en, if_a.ifid_en, if_a.idex_flush}); end
        checks++; if (if_a.stall_cnt !== 16'd1) begin failures++; $display("FAIL load_use_stall_cnt got=%0d exp=1", if_a.stall_cnt); end
        tick();
        idle_inputs();
        DMRd_ex = 1; RD_ex = 7; rs2_id = 7; rs2_used_id = 1; rs1_id = 3; rs1_used_id = 1;
        #1;
        checks++; if ({if_a.pc_en, if_a.ifid_en, if_a.idex_flush} !== 3'b001)
            begin failures++; $display("FAIL load_use_rs2 got=%b exp=001", {if_a.pc_en, if_a.ifid_en, if_a.idex_flush}); end
        tick();
        idle_inputs();
        #1;
        checks++; if (if_a.stall_cnt !== 16'd2) begin failures++; $display("FAIL load_use_stall_cnt2 got=%0d exp=2", if_a.stall_cnt); end
    endtask

    task automatic test_no_stall();
        do_reset();
        DMRd_ex = 1; RD_ex = 0; rs1_id = 0; rs1_used_id = 1;
        #1;
        checks++; if ({if_a.pc_en, if_a.ifid_en, if_a.idex_flush} !== 3'b110)
            begin failures++; $display("FAIL x0_no_stall got=%b exp=110", {if_a.pc_en, if_a.ifid_en, if_a.idex_flush}); end
        tick();
        idle_inputs();
        DMRd_ex = 1; RD_ex = 5; rs1_id = 3; rs1_used_id = 1; rs2_id = 5; rs2_used_id = 0;
        #1;
        checks++; if ({if_a.pc_en, if_a.ifid_en, if_a.idex_flush} !== 3'b110)
            begin failures++; $display("FAIL rs2_unused_no_stall got=%b exp=110", {if_a.pc_en, if_a.ifid_en, if_a.idex_flush}); end
        tick();
        idle_inputs();
        rs1_id = 5; rs1_used_id = 1; RD_ex = 5; DMRd_ex = 0;
        #1;
        checks++; if (if_a.pc_en !== 1'b1) begin failures++; $display("FAIL non_load_no_stall got=%b exp=1", if_a.pc_en); end
        tick();
        idle_inputs();
        #1;
        checks++; if (if_a.stall_cnt !== 16'd0) begin failures++; $display("FAIL no_stall_cnt got=%0d exp=0", if_a.stall_cnt); end
    endtask

    task automatic test_branch();
        do_reset();
        br_taken_ex = 1; DMRd_ex = 1; RD_ex = 5; rs1_id = 5; rs1_used_id = 1;
        #1;
        // ifid_flush, idex_flush, pc_en, ifid_en, exme_en
        checks++; if ({if_a.ifid_flush, if_a.idex_flush, if_a.pc_en, if_a.ifid_en, if_a.exme_en} !== 5'b11111)
            begin failures++; $display("FAIL branch_over_load_use got=%b exp=11111",
                {if_a.ifid_flush, if_a.idex_flush, if_a.pc_en, if_a.ifid_en, if_a.exme_en}); end
        tick();
        idle_inputs();
        #1;
        checks++; if (if_a.flush_cnt !== 16'd1) begin failures++; $display("FAIL branch_flush_cnt got=%0d exp=1", if_a.flush_cnt); end
        checks++; if (if_a.stall_cnt !== 16'd0) begin failures++; $display("FAIL branch_stall_cnt got=%0d exp=0", if_a.stall_cnt); end
    endtask

    task automatic test_mem_wait();
        logic [1:0] exp_state [3] = '{2'b00, 2'b01, 2'b01};
        do_reset();
        dm_req_me = 1; dm_ready = 0; br_taken_ex = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (if_a.state_o !== exp_state[i])
                begin failures++; $display("FAIL mem_wait_state[%0d] got=%b exp=%b", i, if_a.state_o, exp_state[i]); end
            // pc_en, exme_en, mewb_flush, ifid_flush
            checks++; if ({if_a.pc_en, if_a.exme_en, if_a.mewb_flush, if_a.ifid_flush} !== 4'b0010)
                begin failures++; $display("FAIL mem_wait_frozen[%0d] got=%b exp=0010", i,
                    {if_a.pc_en, if_a.exme_en, if_a.mewb_flush, if_a.ifid_flush}); end
            tick();
        end
        br_taken_ex = 0; dm_ready = 1;
        #1;
        checks++; if (if_a.state_o !== 2'b01) begin failures++; $display("FAIL mem_ready_state got=%b exp=01", if_a.state_o); end
        checks++; if ({if_a.pc_en, if_a.exme_en, if_a.mewb_flush} !== 3'b110)
            begin failures++; $display("FAIL mem_ready_outputs got=%b exp=110", {if_a.pc_en, if_a.exme_en, if_a.mewb_flush}); end
        tick();
        idle_inputs();
        #1;
        checks++; if (if_a.state_o !== 2'b00) begin failures++; $display("FAIL mem_back_to_run got=%b exp=00", if_a.state_o); end
        checks++; if (if_a.stall_cnt !== 16'd3) begin failures++; $display("FAIL mem_stall_cnt got=%0d exp=3", if_a.stall_cnt); end
        checks++; if (if_a.flush_cnt !== 16'd0) begin failures++; $display("FAIL mem_flush_cnt got=%0d exp=0", if_a.flush_cnt); end
    endtask

    task automatic test_timeout();
        do_reset();
        dm_req_me = 1; dm_ready = 0;
        tick();
        checks++; if (if_d.state_o !== 2'b10) begin failures++; $display("FAIL timeout1_state got=%b exp=10", if_d.state_o); end
        checks++; if (if_d.mem_err !== 1'b1) begin failures++; $display("FAIL timeout1_mem_err got=%b exp=1", if_d.mem_err); end
        tick();
        tick();
        checks++; if ({if_b.state_o, if_b.mem_err} !== 3'b010)
            begin failures++; $display("FAIL timeout4_before got=%b exp=010", {if_b.state_o, if_b.mem_err}); end
        tick();
        checks++; if ({if_b.state_o, if_b.mem_err} !== 3'b101)
            begin failures++; $display("FAIL timeout4_error got=%b exp=101", {if_b.state_o, if_b.mem_err}); end
        dm_ready = 1;
        #1;
        checks++; if ({if_b.pc_en, if_b.exme_en, if_b.mewb_flush} !== 3'b001)
            begin failures++; $display("FAIL error_frozen got=%b exp=001", {if_b.pc_en, if_b.exme_en, if_b.mewb_flush}); end
        tick();
        tick();
        checks++; if ({if_b.state_o, if_b.mem_err} !== 3'b101)
            begin failures++; $display("FAIL error_sticky got=%b exp=101", {if_b.state_o, if_b.mem_err}); end
        checks++; if (if_b.stall_cnt !== 16'd6) begin failures++; $display("FAIL error_stall_cnt got=%0d exp=6", if_b.stall_cnt); end
        do_reset();
        checks++; if ({if_b.state_o, if_b.mem_err} !== 3'b000)
            begin failures++; $display("FAIL error_reset got=%b exp=000", {if_b.state_o, if_b.mem_err}); end
        checks++; if (if_b.stall_cnt !== 16'd0) begin failures++; $display("FAIL error_reset_cnt got=%0d exp=0", if_b.stall_cnt); end
    endtask

    task automatic test_saturate();
        do_reset();
        dm_req_me = 1; dm_ready = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) begin
                checks++; if (if_c.stall_cnt !== 4'd14) begin failures++; $display("FAIL sat_cnt14 got=%0d exp=14", if_c.stall_cnt); end
            end
            if (i == 15 || i == 20) begin
                checks++; if (if_c.stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_cnt_at_%0d got=%0d exp=15", i, if_c.stall_cnt); end
            end
        end
        checks++; if (if_c.state_o !== 2'b01) begin failures++; $display("FAIL sat_state got=%b exp=01", if_c.state_o); end
        dm_ready = 1;
        tick();
        idle_inputs();
        #1;
        checks++; if ({if_c.state_o, if_c.stall_cnt} !== 6'b00_1111)
            begin failures++; $display("FAIL sat_after_ready got=%b exp=001111", {if_c.state_o, if_c.stall_cnt}); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        DMRd_ex = 1; RD_ex = 9; rs1_id = 9; rs1_used_id = 1;
        tick();
        idle_inputs();
        br_taken_ex = 1;
        #1;
        checks++; if ({if_a.pc_en, if_a.ifid_flush, if_a.idex_flush} !== 3'b111)
            begin failures++; $display("FAIL b2b_branch got=%b exp=111", {if_a.pc_en, if_a.ifid_flush, if_a.idex_flush}); end
        tick();
        idle_inputs();
        DMRd_ex = 1; RD_ex = 4; rs2_id = 4; rs2_used_id = 1;
        tick();
        idle_inputs();
        #1;
        checks++; if ({if_a.stall_cnt, if_a.flush_cnt} !== {16'd2, 16'd1})
            begin failures++; $display("FAIL b2b_counts got=%0d/%0d exp=2/1", if_a.stall_cnt, if_a.flush_cnt); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_saturate();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core. It works alongside the EX-stage forwarding unit and covers the hazards that forwarding cannot resolve.
- Detects load-use hazards, taken-branch/jump redirects and data-memory wait states. It drives per-stage register enables and flushes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Contains a memory-wait FSM with timeout, a sticky error, and saturating performance counters.

Parameters:
- MEM_TIMEOUT, 16, maximum consecutive cycles in MEM_WAIT before entering ERROR (range 1..255).
- CNT_W, 16, width of the stall/flush performance counters.

Ports:
- clk  input  1  core clock
- rst_n  input  1  synchronous active-low reset
- rs1_id  input  5  rs1 address of the instruction in ID
- rs2_id  input  5  rs2 address of the instruction in ID
- rs1_used_id  input  1  ID instruction reads rs1
- rs2_used_id  input  1  ID instruction reads rs2
- RD_ex  input  5  destination register of the instruction in EX
- DMRd_ex  input  1  instruction in EX is a load
- br_taken_ex  input  1  branch/jump in EX redirects the PC
- dm_req_me  input  1  MEM stage is accessing data memory this cycle
- dm_ready  input  1  data memory completes the access this cycle
- pc_en  output  1  PC register enable
- ifid_en  output  1  IF/ID enable
- ifid_flush  output  1  IF/ID loads NOP
- idex_en  output  1  ID/EX enable
- idex_flush  output  1  ID/EX loads bubble (all control = 0)
- exme_en  output  1  EX/MEM enable
- mewb_flush  output  1  MEM/WB loads bubble
- mem_err  output  1  sticky memory-timeout error
- state_o  output  2  FSM state: 00 RUN, 01 MEM_WAIT, 10 ERROR
- stall_cnt  output  CNT_W  cycles with pc_en = 0, saturating
- flush_cnt  output  CNT_W  cycles with ifid_flush = 1, saturating

Behaviour:
- Clocking and reset: single clock. Reset is synchronous, active-low, sampled on the rising edge of clk.
- Values on reset: state = RUN, wait counter = 0, mem_err = 0, stall_cnt = 0, flush_cnt = 0. Reset in any state, including mid-MEM_WAIT or ERROR, returns to RUN on the next edge.
- Output timing: enable/flush outputs are combinational from the registered state and the current inputs (zero latency). Counters and mem_err are registered.
- Default outputs (no hazard): all enables = 1, all flushes = 0.
- load_use = DMRd_ex & (RD_ex != 0) & ((rs1_used_id & rs1_id == RD_ex) | (rs2_used_id & rs2_id == RD_ex)).
- mem_stall = dm_req_me & ~dm_ready.
- RUN, evaluated in priority order:
  1. mem_stall: pc_en = ifid_en = idex_en = exme_en = 0, mewb_flush = 1; next state = MEM_WAIT, wait counter = 1. If MEM_TIMEOUT == 1, next state = ERROR instead.
  2. br_taken_ex: ifid_flush = 1, idex_flush = 1, other enables = 1. This overrides load_use in the same cycle, because the ID instruction is squashed.
  3. load_use: pc_en = 0, ifid_en = 0, idex_flush = 1, exme_en = 1. This gives exactly one bubble; the next cycle EX holds the bubble, so load_use clears and WB forwarding supplies the data.
- MEM_WAIT:
  - Outputs frozen as in RUN priority 1. Branch and load-use are ignored because EX and ID are held.
  - dm_ready = 1: outputs this cycle are the RUN defaults (the access completes and the pipeline advances); next state = RUN, wait counter = 0.
  - Otherwise the wait counter increments. When it reaches MEM_TIMEOUT, next state = ERROR.
- ERROR:
  - Pipeline frozen as in MEM_WAIT; mem_err = 1. Sticky until reset; dm_ready is ignored.
- Counters:
  - stall_cnt increments on every cycle with pc_en = 0.
  - flush_cnt increments on every cycle with ifid_flush = 1.
  - Both saturate at all-ones and never wrap.
- x0 rule: RD_ex == 0 never causes a load-use stall.

Test Plan:
- Load x5 in EX (DMRd_ex = 1, RD_ex = 5) with rs1_id = 5, rs1_used_id = 1 -> one cycle with pc_en = 0, ifid_en = 0, idex_flush = 1; next cycle (DMRd_ex = 0) all enables = 1; stall_cnt = 1.
- Load with RD_ex = 0 and rs1_id = 0 used; separately, rs2_id = 5 with rs2_used_id = 0 -> no stall, all enables = 1.
- br_taken_ex = 1 together with a matching load_use -> ifid_flush = 1, idex_flush = 1, pc_en = 1; flush_cnt = 1, stall_cnt = 0.
- dm_req_me = 1, dm_ready = 0 for 3 cycles, then dm_ready = 1 -> state_o goes 01 for 3 cycles with exme_en = 0 and mewb_flush = 1; then RUN; stall_cnt = 3.
- MEM_TIMEOUT = 4 with dm_ready held 0 -> state_o = 10 and mem_err = 1 after the 4th wait cycle; mem_err stays 1 after dm_ready = 1; rst_n = 0 for one edge -> state_o = 00, mem_err = 0, counters = 0.
- CNT_W = 4 with a 20-cycle memory stall -> stall_cnt saturates at 15 and does not wrap.
